// File: rtl/sw8_in_if.sv
// sw8_in_if: IO-bus signals of the 8-bit switch input port (pins, acknowledge, data/state words).
interface sw8_in_if;
  logic [7:0]  in_pins;
  logic        read_flag;
  logic [31:0] out_data;
  logic [31:0] state_reg;
  modport master (output in_pins, read_flag, input out_data, state_reg);
  modport slave (input in_pins, read_flag, output out_data, state_reg);
endinterface

// File: rtl/sw8_in.sv
// sw8_in: synchronized, debounced 8-bit switch input with sticky valid; optional overrun flag via SW8_OVERRUN_EN.
module sw8_in #(
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic     clock,
  input  logic     reset,
  sw8_in_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [7:0]  s1_q, sync_q, stable_q, stable_d, cand_q, cand_d, data_q, data_d;
  logic [23:0] cnt_q, cnt_d;
  logic        valid_q, valid_d, ov;
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = bus.read_flag ? 1'b0 : valid_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_q != stable_q) begin
          cand_d  = sync_q;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_q != cand_q) begin
          if (sync_q == stable_q) state_d = IDLE;
          else begin
            cand_d = sync_q;
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
          if (cnt_q == LAST) state_d = CAPTURE;
        end
      end
      default: begin
        stable_d = cand_q;
        data_d   = cand_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
`ifdef SW8_OVERRUN_EN
  logic ov_q, ov_d;
  // A capture that coincides with the acknowledge never raises overrun.
  always_comb ov_d = ~bus.read_flag & (ov_q | (state_q == CAPTURE && valid_q));
  assign ov = ov_q;
`else
  assign ov = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef SW8_OVERRUN_EN
      ov_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s1_q     <= bus.in_pins;
      sync_q   <= s1_q;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef SW8_OVERRUN_EN
      ov_q     <= ov_d;
`endif
    end
  end
  assign bus.out_data  = {24'h000000, data_q};
  assign bus.state_reg = {30'h0, ov, valid_q};
endmodule

// File: tb/tb_sw8_in.sv
// tb_sw8_in: directed and randomized checks of sw8_in against a run-length debounce model.
module tb_sw8_in;
  localparam int D = 4;
`ifdef SW8_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  sw8_in_if bus ();
  sw8_in #(.DEBOUNCE_CYCLES(D)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  logic [7:0] dly[$];
  logic [7:0] m_stable, m_out, m_capv;
  logic [8:0] m_runv;
  int m_run;
  bit m_pend, m_valid, m_ov;
  // A value is accepted once it has been the synchronized input for D+1
  // consecutive evaluated edges; the capture itself occupies the next edge.
  task automatic tick();
    logic [7:0] cur;
    @(posedge clock);
    if (reset) begin
      dly = {8'h00, 8'h00};
      m_stable = 8'h00; m_out = 8'h00; m_valid = 0; m_ov = 0;
      m_pend = 0; m_run = 0; m_runv = 9'h100;
    end else begin
      cur = dly[0];
      if (m_pend) begin
        m_ov = !bus.read_flag && (m_ov || (m_valid && OVR_EN));
        m_valid = 1; m_out = m_capv; m_stable = m_capv;
        m_pend = 0; m_run = 0; m_runv = 9'h100;
      end else begin
        if ({1'b0, cur} == m_runv) m_run++;
        else begin m_runv = {1'b0, cur}; m_run = 1; end
        if (cur != m_stable && m_run == D + 1) begin m_pend = 1; m_capv = cur; end
        if (bus.read_flag) begin m_valid = 0; m_ov = 0; end
      end
      dly.push_back(bus.in_pins);
      void'(dly.pop_front());
    end
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse_read();
    bus.read_flag = 1'b1; tick(); bus.read_flag = 1'b0;
  endtask
  task automatic test_reset();
    bus.in_pins = 8'h00; bus.read_flag = 1'b0; reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    checks++;
    if (bus.out_data !== 32'h0 || bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL reset: out_data=%h state_reg=%h want 0/0", bus.out_data, bus.state_reg);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (bus.state_reg !== 32'h0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: state_reg=%h want 0", i, bus.state_reg);
      end
    end
  endtask
  task automatic test_clean();
    bus.in_pins = 8'hA5;
    ticks(7);
    checks++;
    if (bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL clean_early: state_reg=%h want 0", bus.state_reg);
    end
    tick();
    checks++;
    if (bus.state_reg !== 32'h1 || bus.out_data !== 32'h000000A5) begin
      failures++;
      $display("FAIL clean_capture: out_data=%h state_reg=%h want A5/1", bus.out_data, bus.state_reg);
    end
    pulse_read();
    checks++;
    if (bus.state_reg !== 32'h0 || bus.out_data !== 32'h000000A5) begin
      failures++;
      $display("FAIL clean_read: out_data=%h state_reg=%h want A5/0", bus.out_data, bus.state_reg);
    end
  endtask
  task automatic test_bounce();
    bus.in_pins = 8'h00;
    ticks(12);
    pulse_read();
    checks++;
    if (bus.out_data !== 32'h0 || bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL bounce_prep: out_data=%h state_reg=%h want 0/0", bus.out_data, bus.state_reg);
    end
    bus.in_pins = 8'h3C; ticks(2); bus.in_pins = 8'h00;
    ticks(12);
    checks++;
    if (bus.state_reg !== 32'h0 || bus.out_data !== 32'h0) begin
      failures++;
      $display("FAIL bounce_back: out_data=%h state_reg=%h want 0/0", bus.out_data, bus.state_reg);
    end
    bus.in_pins = 8'h3C; ticks(2); bus.in_pins = 8'h3D;
    ticks(7);
    checks++;
    if (bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL bounce_restart: state_reg=%h want 0", bus.state_reg);
    end
    tick();
    checks++;
    if (bus.state_reg !== 32'h1 || bus.out_data !== 32'h3D) begin
      failures++;
      $display("FAIL bounce_third: out_data=%h state_reg=%h want 3D/1", bus.out_data, bus.state_reg);
    end
    ticks(12);
    checks++;
    if (bus.state_reg !== 32'h1 || bus.out_data !== 32'h3D) begin
      failures++;
      $display("FAIL bounce_single: out_data=%h state_reg=%h want 3D/1", bus.out_data, bus.state_reg);
    end
  endtask
  task automatic test_overrun();
    logic [31:0] want;
    want = OVR_EN ? 32'h3 : 32'h1;
    pulse_read();
    bus.in_pins = 8'h11; ticks(10);
    bus.in_pins = 8'h22; ticks(10);
    checks++;
    if (bus.out_data !== 32'h22 || bus.state_reg !== want) begin
      failures++;
      $display("FAIL overrun: out_data=%h state_reg=%h want 22/%h", bus.out_data, bus.state_reg, want);
    end
    pulse_read();
    checks++;
    if (bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL overrun_clear: state_reg=%h want 0", bus.state_reg);
    end
  endtask
  task automatic test_collision();
    bus.in_pins = 8'h77; ticks(7);
    bus.read_flag = 1'b1; tick(); bus.read_flag = 1'b0;
    checks++;
    if (bus.state_reg !== 32'h1 || bus.out_data !== 32'h77) begin
      failures++;
      $display("FAIL collision: out_data=%h state_reg=%h want 77/1", bus.out_data, bus.state_reg);
    end
    pulse_read();
  endtask
  task automatic test_reset_mid();
    bus.in_pins = 8'hFF; ticks(5);
    reset = 1'b1; ticks(2); reset = 1'b0;
    checks++;
    if (bus.out_data !== 32'h0 || bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: out_data=%h state_reg=%h want 0/0", bus.out_data, bus.state_reg);
    end
    ticks(7);
    checks++;
    if (bus.state_reg !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_early: state_reg=%h want 0", bus.state_reg);
    end
    tick();
    checks++;
    if (bus.out_data !== 32'hFF || bus.state_reg !== 32'h1) begin
      failures++;
      $display("FAIL reset_mid_capture: out_data=%h state_reg=%h want FF/1", bus.out_data, bus.state_reg);
    end
  endtask
  task automatic test_random();
    logic [7:0] pal [4] = '{8'h00, 8'h5A, 8'h5B, 8'hC3};
    for (int seg = 0; seg < 300; seg++) begin
      bus.in_pins = pal[$urandom_range(0, 3)];
      reset = ($urandom_range(0, 99) == 0);
      for (int c = $urandom_range(1, 9); c > 0; c--) begin
        bus.read_flag = ($urandom_range(0, 7) == 0);
        tick();
        reset = 1'b0;
        checks++;
        if (bus.out_data !== {24'h0, m_out} || bus.state_reg !== {30'h0, m_ov, m_valid}) begin
          failures++;
          $display("FAIL random seg%0d: out_data=%h state_reg=%h want %h/%h", seg,
                   bus.out_data, bus.state_reg, {24'h0, m_out}, {30'h0, m_ov, m_valid});
        end
      end
    end
    bus.read_flag = 1'b0;
  endtask
  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_overrun();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
